// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, 8N1 by default, 8E1 with UART_RX_PARITY_EN defined
module uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD = 9600,
  parameter int CLKS_PER_TICK = CLK_FREQ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);
  localparam int DW = CLKS_PER_TICK > 1 ? $clog2(CLKS_PER_TICK) : 1;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_t;
  state_t state_q, state_d;
  logic rx_m_q, rx_s_q;
  logic [DW-1:0] div_q, div_d;
  logic [3:0] os_q, os_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  logic tick;
`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d, mis_q, mis_d;
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
  assign tick = div_q == DW'(CLKS_PER_TICK - 1);
  assign rx_data = data_q;
  assign rx_valid = valid_q;
  assign frame_err = ferr_q;
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    div_d = tick ? '0 : div_q + 1'b1;
    os_d = tick ? os_q + 1'b1 : os_q;
    bit_d = bit_q;
    sh_d = sh_q;
    data_d = data_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d = 1'b0;
    mis_d = mis_q;
`endif
    case (state_q)
      IDLE: begin
        div_d = '0;
        os_d = '0;
        bit_d = '0;
`ifdef UART_RX_PARITY_EN
        mis_d = 1'b0;
`endif
        state_d = rx_s_q ? IDLE : START;
      end
      START: if (tick && os_q == 4'd7) begin
        state_d = rx_s_q ? IDLE : DATA;
        os_d = '0;
      end
      DATA: if (tick && os_q == 4'd15) begin
        sh_d = {rx_s_q, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        state_d = bit_q == 3'd7 ? PARITY : DATA;
`else
        state_d = bit_q == 3'd7 ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick && os_q == 4'd15) begin
        mis_d = ^{sh_q, rx_s_q};
        state_d = STOP;
      end
`endif
      STOP: if (tick && os_q == 4'd15) begin
        data_d = sh_q;
        state_d = rx_s_q ? IDLE : BRK;
        ferr_d = !rx_s_q;
`ifdef UART_RX_PARITY_EN
        valid_d = rx_s_q && !mis_q;
        perr_d = rx_s_q && mis_q;
`else
        valid_d = rx_s_q;
`endif
      end
      BRK: state_d = rx_s_q ? IDLE : BRK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      div_q <= '0;
      os_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
      mis_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
      div_q <= div_d;
      os_q <= os_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q <= perr_d;
      mis_q <= mis_d;
`endif
    end
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive counterpart of the team's 9600-baud 8N1 UART transmit path. Runs directly on the 50 MHz board clock and oversamples the serial line at 16x baud. Validates the start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. Presents each received byte with a one-cycle valid strobe to downstream logic (character decoder, LEDs/HEX display).

## Interface
- CLK_FREQ, 50000000: input clock frequency in Hz
- BAUD, 9600: line rate in bit/s
- CLKS_PER_TICK, CLK_FREQ/(BAUD*16): clocks per oversample tick (integer truncation; 325 at defaults)

- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial input; idle high
- rx_data  out  8  last received byte
- rx_valid  out  1  one-cycle strobe: rx_data holds a good frame
- frame_err  out  1  one-cycle strobe: stop bit sampled low
- parity_err  out  1  one-cycle strobe: parity mismatch (tied 0 unless UART_RX_PARITY_EN)
- busy  out  1  high in every state except IDLE

One clock; reset is synchronous and active-high.

## Operation
- rx passes through a 2-flop synchronizer (reset value 1); all logic uses the synchronized signal rx_s.
- Tick divider counts 0..CLKS_PER_TICK-1 and emits a one-clk tick at terminal count. It is cleared on start detection. The oversample counter os_cnt (4 bit) advances on ticks.
- States:
  - IDLE: rx_s==0 → START; clear divider, os_cnt, bit_cnt.
  - START: on the tick where os_cnt==7, sample rx_s. 1 → IDLE (glitch, no strobe). 0 → DATA; os_cnt cleared.
  - DATA: on the tick where os_cnt==15, shift rx_s into the shift register MSB; shifting right, so bit 0 arrives first. bit_cnt++. After the 8th bit → PARITY if the macro is defined, else STOP.
  - PARITY: sample at os_cnt==15 and latch the mismatch → STOP.
  - STOP: sample at os_cnt==15. rx_data ← shift register in both cases.
    - 1 → IDLE. Pulse rx_valid, or pulse parity_err instead if a mismatch was latched.
    - 0 → BREAK. Pulse frame_err.
  - BREAK: wait until rx_s==1 → IDLE. This prevents a held-low line from retriggering.
- At most one of rx_valid, frame_err and parity_err is asserted in any cycle.

## Timing
- Reset values: rx_data=0x00, rx_valid=0, frame_err=0, parity_err=0, busy=0, state=IDLE, synchronizer=1.
- rst mid-frame: abort immediately, no strobe. The next frame is received normally.
- Bit period = 16*CLKS_PER_TICK = 5200 clk.
- Start detect = falling edge + 2 clk (synchronizer) + 1 clk (IDLE→START).
- Samples fall at 8 ticks after start detect, then every 16 ticks.
- Strobe is asserted the clk after the stop-bit sample: ≈ 9.5 bit periods (≈49 400 clk) after the falling edge, ≈10.5 bit periods with parity.
- rx_data stays stable until the next stop sample.
- Back-to-back frames (start edge immediately after stop-bit end) are received with no gap. The receiver is in IDLE about half a bit before the next edge.
- A start glitch shorter than 8 ticks (≈2600 clk) is rejected.

## Configuration
- UART_RX_PARITY_EN defined: frame is 8E1. The PARITY state is present, even parity is checked, and parity_err is driven.
- Undefined: frame is 8N1, there is no PARITY state, and parity_err is constant 0.

## Test plan
- Send 0x55 8N1 at 9600 baud (5208 clk/bit) → one rx_valid pulse, rx_data=0x55, frame_err=0, busy low afterwards.
- Send 0xA5 with stop bit forced low, line held low 3 bit times, then high → frame_err pulse once, rx_data=0xA5, no rx_valid, no second frame until line rises.
- Low glitch of 1000 clk on idle line → no strobe, busy returns 0 within 8 ticks, subsequent 0x3C received correctly.
- Back-to-back 0x00, 0xFF, 0x81 with zero idle → three rx_valid pulses in order with matching data.
- Assert rst for 1 clk during bit 4 of 0x7E, then send 0x12 → no strobe for 0x7E, rx_data=0x12 with rx_valid.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 (wrong; even parity requires 1) → parity_err pulse, rx_data=0x07, no rx_valid. With a correct parity bit → rx_valid.
